// File: rtl/snake_pkg.sv
// Shared constants, state encoding and frame-buffer address helper for the
// snake display path (160x120 logical pixels, 640x480@60 raster).
package snake_pkg;

  localparam int LOG_W    = 160;
  localparam int LOG_H    = 120;
  localparam int FB_DEPTH = 19200;
  localparam int FB_AW    = 15;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } fsm_state_t;

  // y*160 + x as (y<<7)+(y<<5)+x so no multiplier is inferred.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
    logic [FB_AW-1:0] yw;
    yw = {8'd0, y};
    return (yw << 3'd7) + (yw << 3'd5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read port,
// read-before-write on a same-address collision.
module fb_ram_dp
  import snake_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = FB_AW,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rdata_r;

  // Write and read in one block so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/plot_frame_sink.sv
// Pixel-plot receiver: clears the frame buffer after reset, commits plot
// writes, and scans the buffer out as a 4x-replicated 640x480 VGA raster.
module plot_frame_sink
  import snake_pkg::*;
#(
  parameter logic [2:0] BG_COLOUR = BLACK,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  output logic       busy,
  output logic       oob_err,
  output logic       pix_ce,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic [2:0] rgb
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FB_AW-1:0] CLR_LAST = 15'(FB_DEPTH - 1);

  fsm_state_t       state_r;
  logic [FB_AW-1:0] clr_addr_r;
  logic             busy_r;
  logic             oob_err_r;
  logic             pix_ce_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic             hsync_n_r;
  logic             vsync_n_r;
  logic             blank_n_r;
  logic [2:0]       rgb_r;

  logic             in_range_s;
  logic             active_s;
  logic             we_s;
  logic [FB_AW-1:0] waddr_s;
  logic [2:0]       wdata_s;
  logic [FB_AW-1:0] raddr_s;
  logic [2:0]       rdata_s;

  // Plot decode, write-port mux (clear has priority) and scan read address.
  always_comb begin
    in_range_s = (x < 8'(LOG_W)) && (y < 7'(LOG_H));
    active_s   = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    we_s       = 1'b0;
    waddr_s    = clr_addr_r;
    wdata_s    = BG_COLOUR;
    if (active_s) begin
      raddr_s = fb_addr(v_cnt_r[8:2], h_cnt_r[9:2]);
    end else begin
      raddr_s = {FB_AW{1'b0}};
    end
    if (!resetn) begin
      we_s = 1'b0;
    end else if (state_r == S_CLEAR) begin
      we_s    = 1'b1;
      waddr_s = clr_addr_r;
      wdata_s = BG_COLOUR;
    end else begin
      we_s    = plot && in_range_s;
      waddr_s = fb_addr(y, x);
      wdata_s = colour;
    end
  end

  // Clear/run FSM with its registered busy and sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= S_CLEAR;
      clr_addr_r <= {FB_AW{1'b0}};
      busy_r     <= 1'b1;
      oob_err_r  <= 1'b0;
    end else begin
      busy_r <= (state_r == S_CLEAR);
      case (state_r)
        S_CLEAR: begin
          clr_addr_r <= clr_addr_r + 15'd1;
          if (clr_addr_r == CLR_LAST) begin
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          if (plot && !in_range_s) begin
            oob_err_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_CLEAR;
          clr_addr_r <= {FB_AW{1'b0}};
        end
      endcase
    end
  end

  // Pixel tick, raster counters and the one-tick output pipeline.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_ce_r  <= 1'b0;
      h_cnt_r   <= 10'd0;
      v_cnt_r   <= 10'd0;
      hsync_n_r <= 1'b1;
      vsync_n_r <= 1'b1;
      blank_n_r <= 1'b0;
      rgb_r     <= 3'b000;
    end else begin
      pix_ce_r <= ~pix_ce_r;
      if (pix_ce_r) begin
        if (h_cnt_r == H_LAST) begin
          h_cnt_r <= 10'd0;
          if (v_cnt_r == V_LAST) begin
            v_cnt_r <= 10'd0;
          end else begin
            v_cnt_r <= v_cnt_r + 10'd1;
          end
        end else begin
          h_cnt_r <= h_cnt_r + 10'd1;
        end
        // RAM data was fetched on the off-tick clk for this same counter value.
        hsync_n_r <= ~((h_cnt_r >= HS_START) && (h_cnt_r < HS_STOP));
        vsync_n_r <= ~((v_cnt_r >= VS_START) && (v_cnt_r < VS_STOP));
        blank_n_r <= active_s;
        rgb_r     <= (active_s && !busy_r) ? rdata_s : 3'b000;
      end
    end
  end

  fb_ram_dp #(
    .DEPTH (FB_DEPTH),
    .AW    (FB_AW),
    .DW    (3)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  assign busy    = busy_r;
  assign oob_err = oob_err_r;
  assign pix_ce  = pix_ce_r;
  assign hsync_n = hsync_n_r;
  assign vsync_n = vsync_n_r;
  assign blank_n = blank_n_r;
  assign rgb     = rgb_r;

endmodule
